// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port (rw_flag / addr / done handshake) between NPORT
//   cache-side requesters. Each requester has a one-deep pending slot that
//   captures its one-cycle request pulse. Grants are round-robin, starting
//   from the port after the last completed grant. Only one memory transaction
//   is in flight at a time. Its completion pulse and read data are returned
//   to the granted port.
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-low reset
//   port_rw_flag      per port [2i+1:2i]: 01 read, 10 write, 00 idle (pulse)
//   port_addr         per port 32-bit word address
//   port_write_data   per port 32-bit write data
//   port_write_mask   per port 4-bit byte mask
//   port_read_data    read data of the completing transaction (shared)
//   port_done         one-hot completion pulse
//   port_busy         port has a request accepted but not yet completed
//   mem_rw_flag       one-cycle request pulse to memory
//   mem_addr          address to memory, held for the whole transaction
//   mem_write_data    write data to memory, held for the whole transaction
//   mem_write_mask    byte mask to memory, held for the whole transaction
//   mem_read_data     read data from memory, valid with mem_done
//   mem_busy          memory cannot accept a new request
//   mem_done          one-cycle completion pulse from memory
module mem_arbiter #(
  parameter int NPORT = 2,
  parameter int PTR_W = $clog2(NPORT)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [2*NPORT-1:0]   port_rw_flag,
  input  logic [32*NPORT-1:0]  port_addr,
  input  logic [32*NPORT-1:0]  port_write_data,
  input  logic [4*NPORT-1:0]   port_write_mask,
  output logic [31:0]          port_read_data,
  output logic [NPORT-1:0]     port_done,
  output logic [NPORT-1:0]     port_busy,
  output logic [1:0]           mem_rw_flag,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_write_data,
  output logic [3:0]           mem_write_mask,
  input  logic [31:0]          mem_read_data,
  input  logic                 mem_busy,
  input  logic                 mem_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  rr_reg, rr_next;
  logic [PTR_W-1:0]  grant_reg, grant_next;
  logic [1:0]        mem_flag_reg, mem_flag_next;
  logic [31:0]       mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic [3:0]        mem_mask_reg, mem_mask_next;
  logic [NPORT-1:0]  done_reg, done_next;
  logic [31:0]       rdata_reg, rdata_next;

  // Per-port views of the flattened request buses and of the pending slots.
  logic [1:0]        req_flag   [NPORT];
  logic [31:0]       req_addr   [NPORT];
  logic [31:0]       req_wdata  [NPORT];
  logic [3:0]        req_mask   [NPORT];
  logic [1:0]        slot_flag  [NPORT];
  logic [31:0]       slot_addr  [NPORT];
  logic [31:0]       slot_wdata [NPORT];
  logic [3:0]        slot_mask  [NPORT];
  logic [NPORT-1:0]  slot_valid;
  logic [NPORT-1:0]  eligible;

  logic              issue;
  logic              found;
  logic [PTR_W-1:0]  sel;
  int                idx;

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      logic        valid_reg;
      logic [1:0]  flag_reg;
      logic [31:0] addr_reg;
      logic [31:0] wdata_reg;
      logic [3:0]  mask_reg;
      logic        take;

      assign req_flag[gi]  = port_rw_flag[2*gi +: 2];
      assign req_addr[gi]  = port_addr[32*gi +: 32];
      assign req_wdata[gi] = port_write_data[32*gi +: 32];
      assign req_mask[gi]  = port_write_mask[4*gi +: 4];

      assign slot_valid[gi] = valid_reg;
      assign slot_flag[gi]  = flag_reg;
      assign slot_addr[gi]  = addr_reg;
      assign slot_wdata[gi] = wdata_reg;
      assign slot_mask[gi]  = mask_reg;

      // A pulse arriving this cycle can be granted directly, without first
      // passing through the slot.
      assign eligible[gi] = valid_reg | (req_flag[gi] != 2'b00);
      assign take         = issue && (sel == PTR_W'(gi));

      // Busy covers the slot, the in-flight transaction and the done cycle.
      assign port_busy[gi] = valid_reg
                           | ((state_reg == ST_WAIT) && (grant_reg == PTR_W'(gi)))
                           | done_reg[gi];

      always_ff @(posedge CLK) begin
        if (!RST) begin
          valid_reg <= 1'b0;
          flag_reg  <= 2'b00;
          addr_reg  <= '0;
          wdata_reg <= '0;
          mask_reg  <= '0;
        end else if (take) begin
          // Granted: either the slot empties, or the incoming pulse went
          // straight to memory. A pulse that meets a full slot is dropped.
          valid_reg <= 1'b0;
        end else if ((req_flag[gi] != 2'b00) && !valid_reg) begin
          valid_reg <= 1'b1;
          flag_reg  <= req_flag[gi];
          addr_reg  <= req_addr[gi];
          wdata_reg <= req_wdata[gi];
          mask_reg  <= req_mask[gi];
        end
      end
    end
  endgenerate

  // Round-robin pick: first eligible port scanning upward from rr_reg.
  always_comb begin : arb_pick
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (int'(rr_reg) + k) % NPORT;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  always_comb begin : next_state
    state_next     = state_reg;
    rr_next        = rr_reg;
    grant_next     = grant_reg;
    mem_flag_next  = 2'b00;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_mask_next  = mem_mask_reg;
    done_next      = '0;
    rdata_next     = rdata_reg;
    issue          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (found && !mem_busy) begin
          issue      = 1'b1;
          grant_next = sel;
          state_next = ST_WAIT;
          if (slot_valid[sel]) begin
            mem_flag_next  = slot_flag[sel];
            mem_addr_next  = slot_addr[sel];
            mem_wdata_next = slot_wdata[sel];
            mem_mask_next  = slot_mask[sel];
          end else begin
            mem_flag_next  = req_flag[sel];
            mem_addr_next  = req_addr[sel];
            mem_wdata_next = req_wdata[sel];
            mem_mask_next  = req_mask[sel];
          end
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          done_next[grant_reg] = 1'b1;
          rdata_next           = mem_read_data;
          state_next           = ST_IDLE;
          if (int'(grant_reg) == NPORT - 1) begin
            rr_next = '0;
          end else begin
            rr_next = grant_reg + PTR_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg     <= ST_IDLE;
      rr_reg        <= '0;
      grant_reg     <= '0;
      mem_flag_reg  <= 2'b00;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_mask_reg  <= '0;
      done_reg      <= '0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      rr_reg        <= rr_next;
      grant_reg     <= grant_next;
      mem_flag_reg  <= mem_flag_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_mask_reg  <= mem_mask_next;
      done_reg      <= done_next;
      rdata_reg     <= rdata_next;
    end
  end

  assign mem_rw_flag    = mem_flag_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_write_data = mem_wdata_reg;
  assign mem_write_mask = mem_mask_reg;
  assign port_done      = done_reg;
  assign port_read_data = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios with spec-derived constants, followed by a randomized
//   run compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int NPORT = 2;

  logic                CLK = 1'b0;
  logic                RST;
  logic [2*NPORT-1:0]  port_rw_flag;
  logic [32*NPORT-1:0] port_addr;
  logic [32*NPORT-1:0] port_write_data;
  logic [4*NPORT-1:0]  port_write_mask;
  logic [31:0]         port_read_data;
  logic [NPORT-1:0]    port_done;
  logic [NPORT-1:0]    port_busy;
  logic [1:0]          mem_rw_flag;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_write_data;
  logic [3:0]          mem_write_mask;
  logic [31:0]         mem_read_data;
  logic                mem_busy;
  logic                mem_done;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NPORT(NPORT), .PTR_W(1)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .port_rw_flag    (port_rw_flag),
    .port_addr       (port_addr),
    .port_write_data (port_write_data),
    .port_write_mask (port_write_mask),
    .port_read_data  (port_read_data),
    .port_done       (port_done),
    .port_busy       (port_busy),
    .mem_rw_flag     (mem_rw_flag),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_mask  (mem_write_mask),
    .mem_read_data   (mem_read_data),
    .mem_busy        (mem_busy),
    .mem_done        (mem_done)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model (transaction records) ----------------
  typedef struct {
    logic [1:0]  flag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } txn_t;

  txn_t             m_pend [NPORT];
  bit               m_pend_v [NPORT];
  bit               m_fly_v;
  int               m_fly_port;
  int               m_rr;
  logic [1:0]       e_flag;
  logic [31:0]      e_addr, e_wdata, e_rdata;
  logic [3:0]       e_mask;
  logic [NPORT-1:0] e_done, e_busy;

  // Advance the model by one clock edge using the inputs present this cycle.
  task automatic model_edge();
    txn_t inc [NPORT];
    bit   req [NPORT];
    int   pick;
    bit   issued;
    pick   = -1;
    issued = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      inc[i].flag  = port_rw_flag[2*i +: 2];
      inc[i].addr  = port_addr[32*i +: 32];
      inc[i].wdata = port_write_data[32*i +: 32];
      inc[i].mask  = port_write_mask[4*i +: 4];
      req[i]       = (inc[i].flag != 2'b00);
    end
    if (!RST) begin
      for (int i = 0; i < NPORT; i++) m_pend_v[i] = 1'b0;
      m_fly_v = 1'b0; m_fly_port = 0; m_rr = 0;
      e_flag = 0; e_addr = 0; e_wdata = 0; e_mask = 0; e_rdata = 0; e_done = 0; e_busy = 0;
    end else begin
      e_flag = 2'b00;
      e_done = '0;
      if (m_fly_v) begin
        if (mem_done) begin
          e_done[m_fly_port] = 1'b1;
          e_rdata = mem_read_data;
          m_rr    = (m_fly_port + 1) % NPORT;
          m_fly_v = 1'b0;
          $display("txn done: port=%0d addr=%08h rdata=%08h", m_fly_port, e_addr, e_rdata);
        end
      end else if (!mem_busy) begin
        for (int k = 0; k < NPORT; k++) begin
          int p;
          p = (m_rr + k) % NPORT;
          if (pick < 0 && (m_pend_v[p] || req[p])) pick = p;
        end
        if (pick >= 0) begin
          txn_t t;
          t = m_pend_v[pick] ? m_pend[pick] : inc[pick];
          e_flag = t.flag; e_addr = t.addr; e_wdata = t.wdata; e_mask = t.mask;
          m_fly_v = 1'b1; m_fly_port = pick; issued = 1'b1;
        end
      end
      for (int i = 0; i < NPORT; i++) begin
        if (issued && pick == i) m_pend_v[i] = 1'b0;
        else if (req[i] && !m_pend_v[i]) begin
          m_pend_v[i] = 1'b1;
          m_pend[i]   = inc[i];
        end
      end
      for (int i = 0; i < NPORT; i++)
        e_busy[i] = m_pend_v[i] | (m_fly_v && m_fly_port == i) | e_done[i];
    end
  endtask

  // One clock: edge, model update, then settle so outputs can be sampled.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    port_rw_flag = '0; port_addr = '0; port_write_data = '0; port_write_mask = '0;
    mem_read_data = '0; mem_busy = 1'b0; mem_done = 1'b0;
  endtask

  task automatic drive_req(input int p, input logic [1:0] f, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
    port_rw_flag[2*p +: 2]     = f;
    port_addr[32*p +: 32]      = a;
    port_write_data[32*p +: 32] = d;
    port_write_mask[4*p +: 4]  = m;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    set_idle();
    step();
    RST = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b0;
    set_idle();
    step(); step();
    RST = 1'b1;
    checks++; if (mem_rw_flag !== 2'b00) begin errors++; $display("FAIL reset_mem_rw_flag got=%b want=00", mem_rw_flag); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_mem_write_data got=%h want=0", mem_write_data); end
    checks++; if (mem_write_mask !== 4'h0) begin errors++; $display("FAIL reset_mem_write_mask got=%h want=0", mem_write_mask); end
    checks++; if (port_done !== 2'b00) begin errors++; $display("FAIL reset_port_done got=%b want=00", port_done); end
    checks++; if (port_read_data !== 32'h0) begin errors++; $display("FAIL reset_port_read_data got=%h want=0", port_read_data); end
    checks++; if (port_busy !== 2'b00) begin errors++; $display("FAIL reset_port_busy got=%b want=00", port_busy); end
  endtask

  task automatic test_single_read();
    do_reset();
    drive_req(0, 2'b01, 32'h0000_1000, 32'h0, 4'h0);
    step();                                   // cycle 2
    port_rw_flag = '0;
    checks++; if (mem_rw_flag !== 2'b01 || mem_addr !== 32'h1000) begin
      errors++; $display("FAIL single_issue got flag=%b addr=%h want flag=01 addr=00001000", mem_rw_flag, mem_addr); end
    checks++; if (port_busy !== 2'b01) begin errors++; $display("FAIL single_busy_c2 got=%b want=01", port_busy); end
    for (int c = 3; c <= 6; c++) begin
      step();
      checks++; if (mem_rw_flag !== 2'b00 || port_busy !== 2'b01 || port_done !== 2'b00 || mem_addr !== 32'h1000) begin
        errors++; $display("FAIL single_wait_c%0d got flag=%b busy=%b done=%b addr=%h want 00/01/00/00001000",
                           c, mem_rw_flag, port_busy, port_done, mem_addr); end
    end
    mem_done = 1'b1; mem_read_data = 32'hDEADBEEF;
    step();                                   // cycle 7
    mem_done = 1'b0;
    checks++; if (port_done !== 2'b01 || port_read_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_done got done=%b rdata=%h want 01/deadbeef", port_done, port_read_data); end
    checks++; if (port_busy !== 2'b01) begin errors++; $display("FAIL single_busy_c7 got=%b want=01", port_busy); end
    step();                                   // cycle 8
    checks++; if (port_done !== 2'b00 || port_busy !== 2'b00) begin
      errors++; $display("FAIL single_after got done=%b busy=%b want 00/00", port_done, port_busy); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive_req(0, 2'b01, 32'h100, 32'h0, 4'h0);
    drive_req(1, 2'b01, 32'h200, 32'h0, 4'h0);
    step();
    port_rw_flag = '0;
    checks++; if (mem_rw_flag !== 2'b01 || mem_addr !== 32'h100 || port_busy !== 2'b11) begin
      errors++; $display("FAIL same_first got flag=%b addr=%h busy=%b want 01/00000100/11", mem_rw_flag, mem_addr, port_busy); end
    step(); step();
    mem_done = 1'b1; mem_read_data = 32'h1111_1111;
    step();                                   // done + 1
    mem_done = 1'b0;
    checks++; if (port_done !== 2'b01 || mem_rw_flag !== 2'b00) begin
      errors++; $display("FAIL same_done0 got done=%b flag=%b want 01/00", port_done, mem_rw_flag); end
    step();                                   // done + 2
    checks++; if (mem_rw_flag !== 2'b01 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL same_second got flag=%b addr=%h want 01/00000200", mem_rw_flag, mem_addr); end
    step();
    mem_done = 1'b1; mem_read_data = 32'h2222_2222;
    step();
    mem_done = 1'b0;
    checks++; if (port_done !== 2'b10 || port_read_data !== 32'h2222_2222) begin
      errors++; $display("FAIL same_done1 got done=%b rdata=%h want 10/22222222", port_done, port_read_data); end
    // rr pointer wrapped back to port 0: a fresh tie goes to port 0.
    step();
    drive_req(0, 2'b01, 32'h300, 32'h0, 4'h0);
    drive_req(1, 2'b01, 32'h400, 32'h0, 4'h0);
    step();
    port_rw_flag = '0;
    checks++; if (mem_addr !== 32'h300) begin
      errors++; $display("FAIL same_wrap got addr=%h want=00000300", mem_addr); end
  endtask

  task automatic test_fairness();
    int exp_port, got_port;
    do_reset();
    drive_req(0, 2'b01, 32'h1000, 32'h0, 4'h0);
    drive_req(1, 2'b01, 32'h2000, 32'h0, 4'h0);
    step();
    port_rw_flag = '0;
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 10 && mem_rw_flag == 2'b00; c++) step();
      checks++; if (mem_rw_flag === 2'b00) begin
        errors++; $display("FAIL fair_timeout txn=%0d got flag=%b want nonzero", n, mem_rw_flag); end
      exp_port = n % 2;
      got_port = (mem_addr >= 32'h2000) ? 1 : 0;
      checks++; if (got_port != exp_port) begin
        errors++; $display("FAIL fair_grant txn=%0d got port=%0d want=%0d", n, got_port, exp_port); end
      step(); step();
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      checks++; if (port_done !== NPORT'(1 << exp_port)) begin
        errors++; $display("FAIL fair_done txn=%0d got=%b want port %0d", n, port_done, exp_port); end
      // Completed port re-requests in its own done cycle.
      drive_req(exp_port, 2'b01, (exp_port == 1 ? 32'h2000 : 32'h1000) + 32'(4 * (n + 1)), 32'h0, 4'h0);
      step();
      port_rw_flag = '0;
    end
  endtask

  task automatic test_busy_stall();
    do_reset();
    mem_busy = 1'b1;
    drive_req(1, 2'b10, 32'h40, 32'hA5A5_A5A5, 4'b0011);
    step();
    port_rw_flag = '0;
    checks++; if (mem_rw_flag !== 2'b00 || port_busy !== 2'b10) begin
      errors++; $display("FAIL stall_c1 got flag=%b busy=%b want 00/10", mem_rw_flag, port_busy); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (mem_rw_flag !== 2'b00) begin
        errors++; $display("FAIL stall_hold%0d got flag=%b want=00", c, mem_rw_flag); end
    end
    mem_busy = 1'b0;
    step();
    checks++; if (mem_rw_flag !== 2'b10 || mem_addr !== 32'h40 || mem_write_data !== 32'hA5A5_A5A5 || mem_write_mask !== 4'b0011) begin
      errors++; $display("FAIL stall_issue got flag=%b addr=%h data=%h mask=%b want 10/00000040/a5a5a5a5/0011",
                         mem_rw_flag, mem_addr, mem_write_data, mem_write_mask); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (port_done !== 2'b00 || port_busy !== 2'b10) begin
        errors++; $display("FAIL stall_nodone%0d got done=%b busy=%b want 00/10", c, port_done, port_busy); end
    end
    mem_done = 1'b1; mem_read_data = 32'h1234_5678;
    step();
    mem_done = 1'b0;
    checks++; if (port_done !== 2'b10) begin
      errors++; $display("FAIL stall_done got=%b want=10", port_done); end
  endtask

  task automatic test_drop();
    do_reset();
    mem_busy = 1'b1;
    drive_req(0, 2'b01, 32'h20, 32'h0, 4'h0);
    step();
    drive_req(0, 2'b01, 32'h80, 32'h0, 4'h0);
    step();
    port_rw_flag = '0;
    mem_busy = 1'b0;
    step();
    checks++; if (mem_rw_flag !== 2'b01 || mem_addr !== 32'h20) begin
      errors++; $display("FAIL drop_issue got flag=%b addr=%h want 01/00000020", mem_rw_flag, mem_addr); end
    step();
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    checks++; if (port_done !== 2'b01) begin errors++; $display("FAIL drop_done got=%b want=01", port_done); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (mem_rw_flag !== 2'b00 || port_busy !== 2'b00) begin
        errors++; $display("FAIL drop_quiet%0d got flag=%b busy=%b addr=%h want 00/00", c, mem_rw_flag, port_busy, mem_addr); end
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    drive_req(0, 2'b01, 32'h500, 32'h7777_7777, 4'hF);
    step();
    port_rw_flag = '0;
    checks++; if (mem_rw_flag !== 2'b01) begin errors++; $display("FAIL rstwait_issue got=%b want=01", mem_rw_flag); end
    step();
    RST = 1'b0;
    step();
    RST = 1'b1;
    checks++; if ({mem_rw_flag, mem_addr, mem_write_data, mem_write_mask, port_done, port_read_data, port_busy} !== '0) begin
      errors++; $display("FAIL rstwait_clear got flag=%b addr=%h data=%h mask=%h done=%b rdata=%h busy=%b want all zero",
                         mem_rw_flag, mem_addr, mem_write_data, mem_write_mask, port_done, port_read_data, port_busy); end
    mem_done = 1'b1; mem_read_data = 32'hBAD0_BAD0;
    step();
    mem_done = 1'b0;
    checks++; if (port_done !== 2'b00 || port_read_data !== 32'h0) begin
      errors++; $display("FAIL rstwait_stray got done=%b rdata=%h want 00/0", port_done, port_read_data); end
    drive_req(1, 2'b01, 32'h600, 32'h0, 4'h0);
    step();
    port_rw_flag = '0;
    checks++; if (mem_rw_flag !== 2'b01 || mem_addr !== 32'h600) begin
      errors++; $display("FAIL rstwait_new got flag=%b addr=%h want 01/00000600", mem_rw_flag, mem_addr); end
  endtask

  task automatic test_random();
    int lat;
    lat = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < NPORT; p++) begin
        if ($urandom_range(0, 3) == 0)
          drive_req(p, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, $urandom, $urandom, 4'($urandom));
        else
          port_rw_flag[2*p +: 2] = 2'b00;
      end
      mem_busy      = ($urandom_range(0, 3) == 0);
      mem_read_data = $urandom;
      if (m_fly_v) begin
        mem_done = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        mem_done = ($urandom_range(0, 15) == 0);  // stray done while idle
      end
      step();
      if (e_flag != 2'b00) lat = $urandom_range(0, 3);
      checks++;
      if ({mem_rw_flag, mem_addr, mem_write_data, mem_write_mask, port_done, port_read_data, port_busy} !==
          {e_flag, e_addr, e_wdata, e_mask, e_done, e_rdata, e_busy}) begin
        errors++;
        $display("FAIL random cyc=%0d got flag=%b addr=%h data=%h mask=%h done=%b rdata=%h busy=%b want flag=%b addr=%h data=%h mask=%h done=%b rdata=%h busy=%b",
                 cyc, mem_rw_flag, mem_addr, mem_write_data, mem_write_mask, port_done, port_read_data, port_busy,
                 e_flag, e_addr, e_wdata, e_mask, e_done, e_rdata, e_busy);
      end
    end
    set_idle();
  endtask

  initial begin
    RST = 1'b0;
    set_idle();
    test_reset();
    test_single_read();
    test_same_cycle();
    test_fairness();
    test_busy_stall();
    test_drop();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port (`mem_rw_flag`/`mem_addr`/`mem_done` protocol) between NPORT cache-side requesters, e.g. I-cache = port 0, D-cache = port 1.
- Latches one-cycle request pulses and grants round-robin.
- Exactly one memory transaction is outstanding at a time; completion and read data are routed back to the granted requester.
- Sits between the cache instances and the memory/UART controller.

Parameters:
- NPORT, 2, number of requesters (≥2).
- PTR_W, `CLOG2(NPORT)`, width of grant pointer/index.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-low: logic resets on an edge where RST==0.
- port_rw_flag  in  2*NPORT  per port [2i+1:2i]; 01 read, 10 write, 00 none; one-cycle pulse.
- port_addr  in  32*NPORT  per-port word address, sampled with the pulse.
- port_write_data  in  32*NPORT  per-port write data.
- port_write_mask  in  4*NPORT  per-port byte mask.
- port_read_data  out  32  read data of the completing transaction (shared by all ports).
- port_done  out  NPORT  one-cycle completion pulse, one-hot.
- port_busy  out  NPORT  bit i = port i has a latched request not yet completed.
- mem_rw_flag  out  2  to memory; one-cycle pulse per transaction.
- mem_addr  out  32  to memory.
- mem_write_data  out  32  to memory.
- mem_write_mask  out  4  to memory.
- mem_read_data  in  32  from memory, valid with mem_done.
- mem_busy  in  1  memory cannot accept a request.
- mem_done  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset (RST==0 at edge): state=IDLE, rr_ptr=0, all pending slots cleared.
  - Outputs: mem_rw_flag=0, mem_addr=0, mem_write_data=0, mem_write_mask=0, port_done=0, port_read_data=0, port_busy=0.
- Per-port pending slot (1 deep): {flag, addr, wdata, mask}.
  - Loaded when port_rw_flag!=0 and the slot is empty.
  - A request arriving while the slot is full is dropped; the original is kept.
  - Slot cleared at grant; port_busy stays 1 until that port's done pulse.
- eligible[i] = slot_valid[i] | (port_rw_flag[i]!=0). A same-cycle request is grantable without waiting for the latch.
- States:
  - IDLE: if any eligible and !mem_busy → pick first eligible scanning i = rr_ptr, rr_ptr+1, … mod NPORT. Register mem_* from that slot or the incoming request; grant<=i; go to WAIT. Otherwise stay.
  - WAIT: mem_rw_flag forced to 0 after its single pulse cycle; mem_addr/data/mask hold. On mem_done: port_done[grant]<=1, port_read_data<=mem_read_data, rr_ptr<=(grant+1) mod NPORT, go to IDLE.
- Latency:
  - Request pulse in cycle t with arbiter idle and memory free → mem_rw_flag high in cycle t+1.
  - mem_done in cycle d → port_done in cycle d+1.
  - Earliest next mem_rw_flag is d+2.
- Reads and writes are treated identically: a write completes only on mem_done, and port_read_data is don't-care on write completion but is still updated.
- Boundaries:
  - mem_done in IDLE is ignored.
  - mem_busy high in IDLE stalls the issue; the grant decision is re-evaluated each cycle, so a higher-priority arrival may overtake.
  - Simultaneous port_done[i] and a new request from port i: the new request is latched normally.
  - rr_ptr wraps NPORT-1 → 0.
  - Reset during WAIT abandons the transaction; a later stray mem_done is ignored.

Test Plan:
1. Reset, then port0 read pulse addr 0x0000_1000 in cycle 1 → mem_rw_flag=01, mem_addr=0x1000 in cycle 2 only. Then mem_done with mem_read_data=0xDEADBEEF in cycle 6 → port_done=01, port_read_data=0xDEADBEEF in cycle 7; port_busy[0] high cycles 2–7.
2. Port0 and port1 request in the same cycle after reset (rr_ptr=0) → port0 issued first. After its done, port1's latched request is issued with mem_rw_flag in done+2; rr_ptr ends at 0.
3. Fairness: port0 re-requests immediately after each done while port1 holds a pending request → grants alternate 0,1,0,1 over 4 transactions.
4. Port1 write 0xA5A5_A5A5, mask 0011, addr 0x40 with mem_busy=1 for 3 cycles → no mem_rw_flag while busy. Issue occurs the cycle after mem_busy falls with mem_rw_flag=10, mask=0011. port_done[1] fires only after mem_done.
5. Second port0 pulse (addr 0x80) while slot 0 already holds addr 0x20 → only 0x20 reaches memory.
6. Assert RST=0 during WAIT, release, then pulse mem_done → no port_done; all outputs 0; a new request issues normally.
